// File: rtl/alu_seq8.sv
// alu_seq8: sequential 8-bit ALU controller with register file.
// Optional zero flag: define ALU_SEQ8_ZERO_FLAG_EN.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_*             instruction offer (valid/ready handshake)
//   alu_a/b/sel/c_in    registered operands to the external ALU
//   alu_y, alu_c        combinational result/carry from the ALU
//   res_valid/data/rd   one-cycle writeback strobe and payload
//   carry_flag          carry status
//   zero_flag           zero status (constant 0 unless macro)
//   illegal_op          one-cycle pulse on an unknown opcode
//   dbg_addr, dbg_data  combinational register-file read
module alu_seq8 #(
  parameter int RA_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [3:0]      instr_op,
  input  logic [RA_W-1:0] instr_rd,
  input  logic [RA_W-1:0] instr_rs1,
  input  logic [RA_W-1:0] instr_rs2,
  input  logic            instr_imm_en,
  input  logic [7:0]      instr_imm,
  input  logic            instr_use_c,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [3:0]      alu_sel,
  output logic            alu_c_in,
  input  logic [7:0]      alu_y,
  input  logic            alu_c,
  output logic            res_valid,
  output logic [7:0]      res_data,
  output logic [RA_W-1:0] res_rd,
  output logic            carry_flag,
  output logic            zero_flag,
  output logic            illegal_op,
  input  logic [RA_W-1:0] dbg_addr,
  output logic [7:0]      dbg_data
);

  localparam int NREG = 1 << RA_W;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MAX = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t state;

  logic [7:0]      regs [NREG];
  logic [RA_W-1:0] rd_q;
  logic            res_c;
  logic            legal;
  logic            arith;

  // alu_sel is held from acceptance through WB, so it
  // classifies the instruction in flight.
  assign legal = alu_sel <= OP_MAX;
  assign arith = (alu_sel == OP_ADD) || (alu_sel == OP_SUB);

  assign instr_ready = state == IDLE;
  assign dbg_data    = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      alu_c_in   <= 1'b0;
      rd_q       <= '0;
      res_c      <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_rd     <= '0;
      carry_flag <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      res_valid  <= 1'b0;
      illegal_op <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            alu_a   <= regs[instr_rs1];
            alu_b   <= instr_imm_en ? instr_imm
                                    : regs[instr_rs2];
            alu_sel <= instr_op;
            // SUB is a + ~b + 1 inside the ALU
            alu_c_in <= (instr_op == OP_ADD) ?
                        (instr_use_c & carry_flag) :
                        (instr_op == OP_SUB);
            rd_q  <= instr_rd;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_data   <= alu_y;
          res_c      <= alu_c;
          res_rd     <= rd_q;
          res_valid  <= legal;
          illegal_op <= ~legal;
          state      <= WB;
        end
        WB: begin
          if (legal) begin
            regs[res_rd] <= res_data;
            if (arith) carry_flag <= res_c;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ8_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag <= 1'b0;
    end else if (state == WB && legal) begin
      zero_flag <= res_data == 8'h00;
    end
  end
`else
  assign zero_flag = 1'b0;
`endif

endmodule

// File: doc/alu_seq8.md
ALU_SEQ8 -- requirements
Module: alu_seq8

Interface
REQ-001: Parameter RA_W, default 2, register address width; register file holds 2**RA_W 8-bit registers.
REQ-002: clk  input  1  single clock, all state updates on rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: instr_valid  input  1  instruction offered.
REQ-005: instr_ready  output  1  block accepts instruction this cycle.
REQ-006: instr_op  input  4  ALU opcode: ADD 0000, SUB 0001, AND 0010, OR 0011, NAND 0100, NOR 0101, NOT 0110, XOR 0111, XNOR 1000.
REQ-007: instr_rd, instr_rs1, instr_rs2  input  RA_W each  destination and source register indices.
REQ-008: instr_imm_en  input  1  B operand taken from instr_imm instead of rs2.
REQ-009: instr_imm  input  8  immediate operand.
REQ-010: instr_use_c  input  1  ADD uses carry flag as carry-in.
REQ-011: alu_a, alu_b  output  8 each  registered operands to ALU.
REQ-012: alu_sel  output  4  registered opcode to ALU; alu_c_in  output  1  registered carry-in.
REQ-013: alu_y  input  8, alu_c  input  1  combinational ALU result and carry.
REQ-014: res_valid  output  1  one-cycle writeback strobe; res_data  output  8; res_rd  output  RA_W.
REQ-015: carry_flag, zero_flag  output  1 each  status flags.
REQ-016: illegal_op  output  1  one-cycle pulse on unknown opcode.
REQ-017: dbg_addr  input  RA_W; dbg_data  output  8  combinational register-file read.

Function
REQ-018: FSM states IDLE, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-019: IDLE: on instr_valid&instr_ready, latch alu_a=R[rs1], alu_b=instr_imm_en?instr_imm:R[rs2], alu_sel=instr_op, rd; go EXEC.
REQ-020: alu_c_in SHALL be carry_flag for ADD with instr_use_c=1, 1 for SUB, 0 otherwise.
REQ-021: EXEC (one cycle): sample alu_y/alu_c into result register at cycle end; go WB.
REQ-022: WB (one cycle): res_valid=1, res_data=result, res_rd=rd; R[rd] written at end of WB; go IDLE.
REQ-023: Latency: acceptance edge t, res_valid high in cycle t+2, R[rd] visible on dbg_data from t+3; max throughput one instruction per 3 cycles.
REQ-024: Operands are read at acceptance; a write in WB completes before next acceptance, so no RAW hazard exists, including rd==rs1==rs2.
REQ-025: carry_flag SHALL update to alu_c at end of WB for ADD/SUB only; all other ops preserve it.
REQ-026: zero_flag SHALL update to (result==0) at end of WB for every legal op.
REQ-027: Opcode 1001-1111: EXEC proceeds, WB suppressed (res_valid=0, no register/flag write), illegal_op=1 during the WB-state cycle.
REQ-028: alu_a/alu_b/alu_sel/alu_c_in SHALL hold stable from EXEC through WB until next acceptance.
REQ-029: Instruction inputs are ignored while instr_ready=0.

Reset
REQ-030: rst SHALL take priority over all other events, including an acceptance in the same cycle.
REQ-031: After rst: state IDLE, instr_ready=1, all registers 0, alu_a/alu_b/alu_sel/alu_c_in 0, res_valid 0, res_data 0, res_rd 0, carry_flag 0, zero_flag 0, illegal_op 0.
REQ-032: rst during EXEC or WB SHALL abort: no register or flag write, no res_valid.

Configuration
REQ-033: Macro ALU_SEQ8_ZERO_FLAG_EN defined: zero_flag implemented per REQ-026.
REQ-034: Macro undefined: zero_flag logic omitted, port driven constant 0; all other behaviour identical.

Verification
REQ-035: rst; ADD rd=1 rs1=0 imm_en imm=0x3C -> res_valid at t+2, res_data 0x3C, carry 0, zero 0, dbg R1=0x3C.
REQ-036: R1=0xF0; ADD rd=1 rs1=1 imm=0x20 -> 0x10, carry 1; then ADD use_c rd=2 rs1=0 imm=0x00 -> R2=0x01, carry 0.
REQ-037: R1=0x55; SUB rd=3 rs1=1 rs2=1 -> R3=0x00, zero 1 (macro defined) / 0 (undefined), carry=alu_c=1.
REQ-038: op 1010 -> illegal_op pulse at t+2, res_valid 0, registers and flags unchanged.
REQ-039: instr_valid held high with two ADDs -> second accepted exactly 3 cycles after first; instr_ready low in EXEC and WB.
REQ-040: rst asserted in EXEC -> no res_valid, R[rd] stays 0, instr_ready 1 on the cycle after rst deasserts.
